// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe switch traffic generator: LFSR parameters,
// threshold reset defaults and the per-port state encoding.
package pcie_pkg;

    localparam int LFSR_W = 16;
    // Fibonacci taps 16,14,13,11 for a right-shifting register: stage 16 is bit 0
    localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1;

    localparam logic [3:0] UMBRAL_A_RST = 4'd6;
    localparam logic [3:0] UMBRAL_B_RST = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } port_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAP_MASK), cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/pcie_traffic_gen_if.sv
// Data/valid and pause/continue bundle between the traffic generator and the switch.
interface pcie_traffic_gen_if #(
    parameter int NUM_PORTS = 2,
    parameter int BUS_SIZE  = 5
);
    logic [NUM_PORTS*(BUS_SIZE+1)-1:0] data_p;
    logic [NUM_PORTS-1:0]              valid_p;
    logic [NUM_PORTS*2-1:0]            pause_vc;
    logic [NUM_PORTS*2-1:0]            continue_vc;

    modport master (output data_p, output valid_p, input pause_vc, input continue_vc);
    modport slave  (input data_p, input valid_p, output pause_vc, output continue_vc);
endinterface

// File: rtl/pcie_tgen_port.sv
// One generator port: LFSR word source, per-VC pause flags, run FSM and sent counter.
module pcie_tgen_port
    import pcie_pkg::*;
#(
    parameter int                BUS_SIZE  = 5,
    parameter int                CNT_WIDTH = 8,
    parameter logic [LFSR_W-1:0] PORT_SEED = LFSR_SEED ^ 16'h0001
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_acc,
    input  logic [CNT_WIDTH-1:0] num_words,
    input  logic [1:0]           pause,
    input  logic [1:0]           cont,
    output logic [BUS_SIZE:0]    data,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] sent_count,
    output logic                 active,
    output logic                 finished
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    port_state_t          state_reg, state_next;
    logic [LFSR_W-1:0]    lfsr_reg, lfsr_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0] nw_reg, nw_next;
    logic [BUS_SIZE:0]    data_reg, data_next;
    logic                 valid_reg, valid_next;
    logic [1:0]           pause_reg, pause_next;
    logic                 cand_blocked;

    // The candidate's VC is the MSB of the word; its flag decides emit vs hold
    assign cand_blocked = pause_reg[lfsr_reg[BUS_SIZE]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            lfsr_reg  <= PORT_SEED;
            cnt_reg   <= '0;
            nw_reg    <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            pause_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            cnt_reg   <= cnt_next;
            nw_reg    <= nw_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            pause_reg <= pause_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        cnt_next   = cnt_reg;
        nw_next    = nw_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        pause_next = (pause_reg & ~cont) | pause;

        case (state_reg)
            // A finished port restarts directly on the next accepted start
            IDLE, DONE: begin
                if (start_acc) begin
                    nw_next    = num_words;
                    cnt_next   = '0;
                    state_next = (num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!cand_blocked) begin
                    data_next  = lfsr_reg[BUS_SIZE:0];
                    valid_next = 1'b1;
                    lfsr_next  = lfsr_step(lfsr_reg);
                    cnt_next   = cnt_reg + CNT_ONE;
                    if (cnt_reg + CNT_ONE == nw_reg) begin
                        state_next = DONE;
                    end
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!cand_blocked) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign data       = data_reg;
    assign valid      = valid_reg;
    assign sent_count = cnt_reg;
    assign active     = (state_reg == RUN) || (state_reg == HOLD);
    assign finished   = (state_reg == DONE);

endmodule

// File: rtl/pcie_traffic_gen.sv
// LFSR traffic generator driving NUM_PORTS switch inputs, plus the switch
// almost-full/almost-empty threshold registers and run-level busy/done.
module pcie_traffic_gen
    import pcie_pkg::*;
#(
    parameter int                NUM_PORTS = 2,
    parameter int                BUS_SIZE  = 5,
    parameter int                CNT_WIDTH = 8,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_SEED
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           num_words,
    input  logic [3:0]                     cfg_umbral_a,
    input  logic [3:0]                     cfg_umbral_b,
    output logic [3:0]                     umbralA,
    output logic [3:0]                     umbralB,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] sent_count,
    output logic                           busy,
    output logic                           done,
    pcie_traffic_gen_if.master             bus
);
    logic [NUM_PORTS-1:0]              active_w;
    logic [NUM_PORTS-1:0]              finished_w;
    logic [NUM_PORTS-1:0]              valid_w;
    logic [NUM_PORTS*(BUS_SIZE+1)-1:0] data_w;
    logic                              start_acc;
    logic [3:0]                        umbral_a_reg;
    logic [3:0]                        umbral_b_reg;
    logic                              done_reg;

    assign busy      = |active_w;
    assign start_acc = start & ~busy;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            pcie_tgen_port #(
                .BUS_SIZE  (BUS_SIZE),
                .CNT_WIDTH (CNT_WIDTH),
                .PORT_SEED (SEED ^ LFSR_W'(gi + 1))
            ) u_port (
                .clk        (clk),
                .reset      (reset),
                .start_acc  (start_acc),
                .num_words  (num_words),
                .pause      (bus.pause_vc[2*gi +: 2]),
                .cont       (bus.continue_vc[2*gi +: 2]),
                .data       (data_w[gi*(BUS_SIZE+1) +: BUS_SIZE+1]),
                .valid      (valid_w[gi]),
                .sent_count (sent_count[gi*CNT_WIDTH +: CNT_WIDTH]),
                .active     (active_w[gi]),
                .finished   (finished_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            umbral_a_reg <= UMBRAL_A_RST;
            umbral_b_reg <= UMBRAL_B_RST;
            done_reg     <= 1'b0;
        end else if (start_acc) begin
            umbral_a_reg <= cfg_umbral_a;
            umbral_b_reg <= cfg_umbral_b;
            done_reg     <= 1'b0;
        end else begin
            done_reg     <= &finished_w;
        end
    end

    assign umbralA     = umbral_a_reg;
    assign umbralB     = umbral_b_reg;
    assign done        = done_reg;
    assign bus.data_p  = data_w;
    assign bus.valid_p = valid_w;

endmodule

// File: tb/tb_pcie_traffic_gen.sv
// Directed bench for pcie_traffic_gen: reset, basic run, back-pressure, edge cases.
module tb_pcie_traffic_gen;
    localparam int          NP   = 2;
    localparam int          BS   = 5;
    localparam int          CW   = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_words = 8'd0;
    logic [3:0]  cfg_a = 4'd0;
    logic [3:0]  cfg_b = 4'd0;
    logic [3:0]  umbralA, umbralB;
    logic [15:0] sent_count;
    logic        busy, done;
    logic [15:0] m_lfsr [2];
    int          checks = 0;
    int          errors = 0;

    pcie_traffic_gen_if #(.NUM_PORTS(NP), .BUS_SIZE(BS)) bus ();

    pcie_traffic_gen #(.NUM_PORTS(NP), .BUS_SIZE(BS), .CNT_WIDTH(CW), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .cfg_umbral_a(cfg_a), .cfg_umbral_b(cfg_b), .umbralA(umbralA), .umbralB(umbralB),
        .sent_count(sent_count), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, stage 16 at bit 0, shifting toward bit 0
    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic fb;
        fb = l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11];
        return {fb, l[15:1]};
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; num_words = 8'd0;
        bus.pause_vc = 2'b00; bus.continue_vc = 2'b00;
        m_lfsr[0] = SEED ^ 16'd1;
        m_lfsr[1] = SEED ^ 16'd2;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge just after the edge that sampled start
    task automatic pulse_start(input logic [7:0] nw, input logic [3:0] ua, input logic [3:0] ub);
        num_words = nw; cfg_a = ua; cfg_b = ub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        bus.pause_vc = 2'b00; bus.continue_vc = 2'b00;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.valid_p !== 2'b00) begin errors++; $display("FAIL rst_valid: got %0h expected 0", bus.valid_p); end
        checks++; if (umbralA !== 4'd6) begin errors++; $display("FAIL rst_umbralA: got %0d expected 6", umbralA); end
        checks++; if (umbralB !== 4'd3) begin errors++; $display("FAIL rst_umbralB: got %0d expected 3", umbralB); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_done_busy: got %b%b expected 00", done, busy); end
        checks++; if (sent_count !== 16'h0000) begin errors++; $display("FAIL rst_sent: got %0h expected 0", sent_count); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        pulse_start(8'd4, 4'd10, 4'd4);
        checks++; if (busy !== 1'b1 || bus.valid_p !== 2'b00) begin errors++; $display("FAIL basic_start: got busy=%b valid=%0h expected busy=1 valid=0", busy, bus.valid_p); end
        checks++; if (umbralA !== 4'd10 || umbralB !== 4'd4) begin errors++; $display("FAIL basic_umbral: got %0d/%0d expected 10/4", umbralA, umbralB); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (bus.valid_p !== 2'b11) begin errors++; $display("FAIL basic_valid[%0d]: got %0h expected 3", k, bus.valid_p); end
            checks++; if (bus.data_p[5:0] !== m_lfsr[0][5:0]) begin errors++; $display("FAIL basic_data0[%0d]: got %0h expected %0h", k, bus.data_p[5:0], m_lfsr[0][5:0]); end
            checks++; if (bus.data_p[11:6] !== m_lfsr[1][5:0]) begin errors++; $display("FAIL basic_data1[%0d]: got %0h expected %0h", k, bus.data_p[11:6], m_lfsr[1][5:0]); end
            checks++; if (sent_count !== {8'(k + 1), 8'(k + 1)}) begin errors++; $display("FAIL basic_sent[%0d]: got %0h expected %0d/%0d", k, sent_count, k + 1, k + 1); end
            m_lfsr[0] = ref_step(m_lfsr[0]);
            m_lfsr[1] = ref_step(m_lfsr[1]);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_last: got busy=%b done=%b expected 0 0", busy, done); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || bus.valid_p !== 2'b00) begin errors++; $display("FAIL basic_done: got done=%b valid=%0h expected 1 0", done, bus.valid_p); end
        checks++; if (sent_count !== 16'h0404) begin errors++; $display("FAIL basic_sent_final: got %0h expected 0404", sent_count); end
    endtask

    task automatic test_backpressure();
        int lead, p0, p1, resume_cyc;
        logic [15:0] t;
        logic exp1;
        do_reset();
        t = m_lfsr[0]; lead = 0;
        while (lead < 20 && t[5] == 1'b0) begin t = ref_step(t); lead++; end
        checks++; if (lead >= 20) begin errors++; $display("FAIL bp_lead: got %0d leading VC0 words expected fewer than 20", lead); end
        bus.pause_vc = 2'b10;
        @(negedge clk);
        bus.pause_vc = 2'b00;
        pulse_start(8'd20, 4'd6, 4'd3);
        p0 = 0; p1 = 0; resume_cyc = 0;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            @(negedge clk);
            bus.pause_vc = 2'b00; bus.continue_vc = 2'b00;
            if (cyc <= lead) begin
                checks++; if (bus.valid_p[0] !== 1'b1) begin errors++; $display("FAIL bp_pre_valid0[%0d]: got %b expected 1", cyc, bus.valid_p[0]); end
            end else if (cyc <= lead + 6) begin
                checks++; if (bus.valid_p[0] !== 1'b0) begin errors++; $display("FAIL bp_hold_valid0[%0d]: got %b expected 0", cyc, bus.valid_p[0]); end
            end
            if (cyc == lead + 6) begin
                checks++; if (sent_count[7:0] !== 8'(lead)) begin errors++; $display("FAIL bp_hold_sent0: got %0d expected %0d", sent_count[7:0], lead); end
            end
            if (bus.valid_p[0] === 1'b1) begin
                checks++; if (bus.data_p[5:0] !== m_lfsr[0][5:0]) begin errors++; $display("FAIL bp_data0[%0d]: got %0h expected %0h", cyc, bus.data_p[5:0], m_lfsr[0][5:0]); end
                m_lfsr[0] = ref_step(m_lfsr[0]);
                p0++;
                if (cyc > lead && resume_cyc == 0) resume_cyc = cyc;
            end
            exp1 = (p1 < 20);
            checks++; if (bus.valid_p[1] !== exp1) begin errors++; $display("FAIL bp_valid1[%0d]: got %b expected %b", cyc, bus.valid_p[1], exp1); end
            if (exp1) begin
                checks++; if (bus.data_p[11:6] !== m_lfsr[1][5:0]) begin errors++; $display("FAIL bp_data1[%0d]: got %0h expected %0h", cyc, bus.data_p[11:6], m_lfsr[1][5:0]); end
                m_lfsr[1] = ref_step(m_lfsr[1]);
                p1++;
            end
            // Pause and continue together must leave the flag set
            if (cyc == lead + 2) begin bus.pause_vc = 2'b10; bus.continue_vc = 2'b10; end
            if (cyc == lead + 5) bus.continue_vc = 2'b10;
            if (done === 1'b1) break;
        end
        checks++; if (resume_cyc == 0 || resume_cyc > lead + 10) begin errors++; $display("FAIL bp_resume: got cycle %0d expected %0d..%0d", resume_cyc, lead + 7, lead + 10); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done); end
        checks++; if (sent_count !== 16'h1414) begin errors++; $display("FAIL bp_sent: got %0h expected 1414", sent_count); end
        checks++; if (p0 != 20) begin errors++; $display("FAIL bp_p0_words: got %0d expected 20", p0); end
    endtask

    task automatic test_start_while_busy();
        do_reset();
        pulse_start(8'd10, 4'd7, 4'd2);
        repeat (3) @(negedge clk);
        checks++; if (sent_count[7:0] !== 8'd3) begin errors++; $display("FAIL swb_pre: got %0d expected 3", sent_count[7:0]); end
        pulse_start(8'd2, 4'd12, 4'd1);
        checks++; if (sent_count !== 16'h0404) begin errors++; $display("FAIL swb_sent: got %0h expected 0404", sent_count); end
        checks++; if (umbralA !== 4'd7 || umbralB !== 4'd2) begin errors++; $display("FAIL swb_umbral: got %0d/%0d expected 7/2", umbralA, umbralB); end
        for (int c = 0; c < 20 && done !== 1'b1; c++) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL swb_done: got %b expected 1", done); end
        checks++; if (sent_count !== 16'h0A0A) begin errors++; $display("FAIL swb_sent_final: got %0h expected 0a0a", sent_count); end
    endtask

    task automatic test_zero_words();
        do_reset();
        pulse_start(8'd1, 4'd6, 4'd3);
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zw_prior_done: got %b expected 1", done); end
        pulse_start(8'd0, 4'd9, 4'd2);
        checks++; if (umbralA !== 4'd9 || umbralB !== 4'd2) begin errors++; $display("FAIL zw_umbral: got %0d/%0d expected 9/2", umbralA, umbralB); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zw_cleared: got done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (sent_count !== 16'h0000) begin errors++; $display("FAIL zw_sent: got %0h expected 0", sent_count); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || bus.valid_p !== 2'b00) begin errors++; $display("FAIL zw_done: got done=%b valid=%0h expected 1 0", done, bus.valid_p); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        pulse_start(8'd8, 4'd11, 4'd5);
        repeat (2) @(negedge clk);
        checks++; if (sent_count !== 16'h0202) begin errors++; $display("FAIL rmr_pre: got %0h expected 0202", sent_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.valid_p !== 2'b00) begin errors++; $display("FAIL rmr_valid: got %0h expected 0", bus.valid_p); end
        checks++; if (sent_count !== 16'h0000 || busy !== 1'b0) begin errors++; $display("FAIL rmr_sent_busy: got %0h busy=%b expected 0 0", sent_count, busy); end
        checks++; if (umbralA !== 4'd6 || umbralB !== 4'd3) begin errors++; $display("FAIL rmr_umbral: got %0d/%0d expected 6/3", umbralA, umbralB); end
        @(negedge clk);
        reset = 1'b0;
        m_lfsr[0] = SEED ^ 16'd1;
        m_lfsr[1] = SEED ^ 16'd2;
        @(negedge clk);
        pulse_start(8'd3, 4'd6, 4'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.valid_p !== 2'b11 || bus.data_p !== {m_lfsr[1][5:0], m_lfsr[0][5:0]}) begin errors++; $display("FAIL rmr_replay[%0d]: got valid=%0h data=%0h expected 3 %0h", k, bus.valid_p, bus.data_p, {m_lfsr[1][5:0], m_lfsr[0][5:0]}); end
            m_lfsr[0] = ref_step(m_lfsr[0]);
            m_lfsr[1] = ref_step(m_lfsr[1]);
        end
    endtask

    initial begin
        bus.pause_vc = 2'b00;
        bus.continue_vc = 2'b00;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_zero_words();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
